// File: rtl/out_port_allocator_4_pkg.sv
// Shared types and helpers for the wormhole output-port allocator.
package out_port_allocator_4_pkg;

    localparam int N_IN_DEF = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic logic [31:0] idx_to_onehot(input int unsigned idx);
        return 32'(1) << idx;
    endfunction

    // Highest set bit wins; callers pass a true one-hot vector.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if (oh[i]) r = i;
        return r;
    endfunction

endpackage

// File: rtl/out_port_allocator_4_rr_arbiter.sv
// Combinational round-robin pick: first candidate at or after ptr, wrapping.
module rr_arbiter_4 #(
    parameter int N_IN = 4,
    parameter int IW   = 2
) (
    input  logic [N_IN-1:0] cand,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   win,
    output logic            any_valid
);

    int d;
    int best;

    // Smallest wrapped distance from ptr among the candidates wins.
    always_comb begin
        win       = '0;
        any_valid = |cand;
        best      = N_IN;
        d         = 0;
        for (int i = 0; i < N_IN; i++) begin
            d = (i + N_IN - int'(ptr)) % N_IN;
            if (cand[i] && d < best) begin
                best = d;
                win  = IW'(i);
            end
        end
    end

endmodule

// File: rtl/out_port_allocator_4.sv
// Wormhole output-port allocator: locks one input from head to tail and
// drives the crossbar select plus per-input acceptance handshakes.
module out_port_allocator_4
    import out_port_allocator_4_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_IN-1:0] req_in,
    input  logic [N_IN-1:0] valid_in,
    input  logic [N_IN-1:0] tail_in,
    input  logic            out_ready,
    output logic [N_IN-1:0] mux_sel,
    output logic            valid_out,
    output logic [N_IN-1:0] grant_ack
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t          state, state_nxt;
    logic [IW-1:0]   own, rr_ptr, win_idx;
    logic [N_IN-1:0] cand;
    logic            any_cand, own_acc, pkt_end;

    assign cand = req_in & valid_in;

    rr_arbiter_4 #(.N_IN(N_IN), .IW(IW)) u_arb (
        .cand      (cand),
        .ptr       (rr_ptr),
        .win       (win_idx),
        .any_valid (any_cand)
    );

    // Outputs depend only on registered state, valid_in and out_ready.
    always_comb begin
        state_nxt = state;
        valid_out = 1'b0;
        grant_ack = '0;
        own_acc   = 1'b0;
        pkt_end   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_cand) state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                own_acc        = valid_in[own] & out_ready;
                valid_out      = valid_in[own];
                grant_ack[own] = own_acc;
                pkt_end        = own_acc & tail_in[own];
                if (pkt_end) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            own     <= '0;
            rr_ptr  <= '0;
            mux_sel <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_cand) begin
                own     <= win_idx;
                mux_sel <= N_IN'(idx_to_onehot(32'(win_idx)));
            end else if (pkt_end) begin
                // Pointer only advances when a packet closes, never on a grant.
                mux_sel <= '0;
                rr_ptr  <= (own == IW'(N_IN - 1)) ? '0 : own + 1'b1;
            end
        end
    end

endmodule
